inst_fetch_ctrl: RTL

- Sequences the instruction memory for the single-cycle RISC-V core.
- Holds the PC and drives the instruction memory word address, then registers the returned word into a valid/ready output stage toward decode.
- Handles start/halt, branch/jump redirects with flush, address-range and alignment faults, and counts retired fetches.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_out_reg.sv | 41 ++++
 rtl/inst_fetch_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding and geometry helpers for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // Byte-offset bits inside one memory word.
    function automatic int calc_off(input int bits);
        return $clog2(bits / 8);
    endfunction

    // Bytes per memory word, i.e. the sequential pc increment.
    function automatic int calc_step(input int bits);
        return bits / 8;
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output stage toward decode: flush clears valid, load captures a word,
// otherwise the held word stays stable.
module fetch_out_reg #(
    parameter int BITS = 64,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [BITS-1:0] i_inst,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_valid,
    output logic [BITS-1:0] o_inst,
    output logic [PC_W-1:0] o_pc
);

    logic            r_valid;
    logic [BITS-1:0] r_inst;
    logic [PC_W-1:0] r_pc;

    // Flush wins over load; the held word/pc are left untouched on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the pc, addresses instruction memory, handles
// start/halt, redirects, range/alignment faults and counts accepted words.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 32,
    parameter int          BITS     = 64,
    parameter int          ADDR_W   = 6,
    parameter int          PC_W     = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              halt_i,
    input  logic              redirect_valid_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [BITS-1:0]   mem_rdata_i,
    output logic [BITS-1:0]   inst_o,
    output logic [PC_W-1:0]   inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic              busy_o,
    output logic              fault_o,
    output logic [31:0]       fetch_count_o
);

    localparam int OFF  = calc_off(BITS);
    localparam int STEP = calc_step(BITS);

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_fault;
    logic [31:0]     r_count;

    logic [PC_W-1:0] w_word_idx;
    logic [PC_W-1:0] w_redir_idx;
    logic            w_pc_oor;
    logic            w_redir_bad;
    logic            w_in_fetch;
    logic            w_advance;
    logic            w_accept;
    logic            w_redir_take;
    logic            w_load;
    logic            w_flush;

    assign w_word_idx   = r_pc >> OFF;
    assign w_redir_idx  = redirect_pc_i >> OFF;
    assign w_pc_oor     = (w_word_idx >= PC_W'(DEPTH));
    assign w_redir_bad  = (redirect_pc_i[OFF-1:0] != '0) || (w_redir_idx >= PC_W'(DEPTH));
    assign w_in_fetch   = (r_state == FETCH);
    assign w_advance    = !inst_valid_o || inst_ready_i;
    assign w_accept     = inst_valid_o && inst_ready_i;
    assign w_redir_take = w_in_fetch && !halt_i && redirect_valid_i;

    // Any exit from normal sequencing (halt, redirect, fault, not fetching) drops valid.
    assign w_flush = !w_in_fetch || halt_i || redirect_valid_i || (w_advance && w_pc_oor);
    assign w_load  = w_in_fetch && w_advance && !w_pc_oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= PC_W'(RESET_PC);
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HALTED: begin
                    if (start_i) begin
                        r_state <= FETCH;
                        r_pc    <= PC_W'(RESET_PC);
                        r_fault <= 1'b0;
                    end
                end
                FETCH: begin
                    if (halt_i) begin
                        r_state <= HALTED;
                    end else if (redirect_valid_i) begin
                        if (w_redir_bad) begin
                            r_fault <= 1'b1;
                            r_state <= HALTED;
                        end else begin
                            r_pc <= redirect_pc_i;
                        end
                    end else if (w_advance) begin
                        if (w_pc_oor) begin
                            r_fault <= 1'b1;
                            r_state <= HALTED;
                        end else begin
                            r_pc <= r_pc + PC_W'(STEP);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A word accepted in the same cycle as a redirect is discarded, so it is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept && !w_redir_take && (r_count != '1)) begin
            r_count <= r_count + 32'd1;
        end
    end

    fetch_out_reg #(
        .BITS (BITS),
        .PC_W (PC_W)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_inst  (mem_rdata_i),
        .i_pc    (r_pc),
        .o_valid (inst_valid_o),
        .o_inst  (inst_o),
        .o_pc    (inst_pc_o)
    );

    assign mem_addr_o    = r_pc[ADDR_W+OFF-1:OFF];
    assign busy_o        = w_in_fetch;
    assign fault_o       = r_fault;
    assign fetch_count_o = r_count;

endmodule
